// File: rtl/bshift_pkg.sv
// bshift_pkg: mode encoding, per-beat control bundle and stage distance helper
// shared by the pipelined barrel shifter.
package bshift_pkg;

    typedef enum logic [1:0] {
        BS_LSL = 2'b00,
        BS_LSR = 2'b01,
        BS_ROL = 2'b10,
        BS_ROR = 2'b11
    } bshift_mode_t;

    // Control that travels with every beat; data, amount and carry are
    // width-dependent and are wrapped around this in the top.
    typedef struct packed {
        bshift_mode_t mode;
        logic         arith;
    } bshift_ctl_t;

    function automatic int bs_dist(input int k, input int dsize);
        return (2 ** k) % dsize;
    endfunction

endpackage

// File: rtl/bshift_if.sv
// bshift_if: valid/ready input and output channels of bshift_pipe
// (out_carry only present with BSHIFT_CARRY_EN).
interface bshift_if #(
    parameter int DSIZE = 64,
    parameter int ASIZE = $clog2(DSIZE)
);
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] in_data;
    logic [ASIZE-1:0] in_amount;
    logic [1:0]       in_mode;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;
`ifdef BSHIFT_CARRY_EN
    logic             out_carry;
`endif

    modport master (
        output in_valid, in_data, in_amount, in_mode, in_arith, out_ready,
`ifdef BSHIFT_CARRY_EN
        input  out_carry,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_mode, in_arith, out_ready,
`ifdef BSHIFT_CARRY_EN
        output out_carry,
`endif
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/bshift_stage.sv
// bshift_stage: combinational shift/rotate by 2^K, enabled by one amount bit;
// carry logic only with BSHIFT_CARRY_EN.
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int K     = 0
) (
    input  logic [DSIZE-1:0] data,
    input  logic             en,
    input  bshift_ctl_t      ctl,
`ifdef BSHIFT_CARRY_EN
    input  logic             cin,
    output logic             cout,
`endif
    output logic [DSIZE-1:0] res
);

    localparam int P    = 2 ** K;
    localparam bit FULL = (P >= DSIZE);
    localparam int SH   = FULL ? DSIZE : P;
    localparam int D    = bs_dist(K, DSIZE);

    logic             fill;
    logic [DSIZE-1:0] lsl;
    logic [DSIZE-1:0] lsr;
    logic [DSIZE-1:0] rol;
    logic [DSIZE-1:0] ror;

    always_comb begin
        // ASR keeps the MSB at the sign, so it stays valid stage to stage
        fill = ctl.arith & data[DSIZE-1];
        lsl  = data << SH;
        lsr  = fill ? ~((~data) >> SH) : (data >> SH);
        rol  = (data << D) | (data >> (DSIZE - D));
        ror  = (data >> D) | (data << (DSIZE - D));
        res  = data;
        if (en) begin
            unique case (ctl.mode)
                BS_LSL: res = lsl;
                BS_LSR: res = lsr;
                BS_ROL: res = rol;
                BS_ROR: res = ror;
            endcase
        end
    end

`ifdef BSHIFT_CARRY_EN
    localparam int LI  = DSIZE - P;
    localparam int RI  = P - 1;
    localparam bit LOK = (LI >= 0) && (LI < DSIZE);
    localparam bit ROK = (RI < DSIZE);
    localparam int LIX = LOK ? LI : 0;
    localparam int RIX = ROK ? RI : 0;
    localparam int WL  = (DSIZE - D) % DSIZE;
    localparam int WR  = (D + DSIZE - 1) % DSIZE;

    always_comb begin
        cout = cin;
        if (en) begin
            unique case (ctl.mode)
                BS_LSL: cout = LOK ? data[LIX] : 1'b0;
                BS_LSR: cout = ROK ? data[RIX] : fill;
                BS_ROL: cout = data[WL];
                BS_ROR: cout = data[WR];
            endcase
        end
    end
`endif

endmodule

// File: rtl/bshift_pipe.sv
// bshift_pipe: ASIZE-stage pipelined barrel shifter with global stall;
// define BSHIFT_CARRY_EN to add the piped carry and out_carry.
module bshift_pipe
    import bshift_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int ASIZE = $clog2(DSIZE)
) (
    input logic     clk,
    input logic     rst,
    bshift_if.slave io
);

    // Amount is shifted down one bit per stage so each stage reads bit 0.
    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [ASIZE-1:0] amt;
        bshift_ctl_t      ctl;
`ifdef BSHIFT_CARRY_EN
        logic             carry;
`endif
    } beat_t;

    logic             adv;
    logic [ASIZE-1:0] vq;
    beat_t            pq  [ASIZE];
    beat_t            src [ASIZE];
    logic [DSIZE-1:0] res [ASIZE];
`ifdef BSHIFT_CARRY_EN
    logic             cout [ASIZE];
`endif

    assign adv          = !io.out_valid || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = vq[ASIZE-1];
    assign io.out_data  = pq[ASIZE-1].data;
`ifdef BSHIFT_CARRY_EN
    assign io.out_carry = pq[ASIZE-1].carry;
`endif

    always_comb begin
        src[0].data      = io.in_data;
        src[0].amt       = io.in_amount;
        src[0].ctl.mode  = bshift_mode_t'(io.in_mode);
        src[0].ctl.arith = io.in_arith;
`ifdef BSHIFT_CARRY_EN
        src[0].carry     = 1'b0;
`endif
        for (int k = 1; k < ASIZE; k++) begin
            src[k] = pq[k-1];
        end
    end

    for (genvar k = 0; k < ASIZE; k++) begin : g_st
        bshift_stage #(
            .DSIZE(DSIZE),
            .K    (k)
        ) u_st (
            .data(src[k].data),
            .en  (src[k].amt[0]),
            .ctl (src[k].ctl),
`ifdef BSHIFT_CARRY_EN
            .cin (src[k].carry),
            .cout(cout[k]),
`endif
            .res (res[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vq <= '0;
            for (int k = 0; k < ASIZE; k++) begin
                pq[k] <= '0;
            end
        end else if (adv) begin
            vq <= ASIZE'({vq, io.in_valid});
            for (int k = 0; k < ASIZE; k++) begin
                pq[k].data <= res[k];
                pq[k].amt  <= src[k].amt >> 1;
                pq[k].ctl  <= src[k].ctl;
`ifdef BSHIFT_CARRY_EN
                pq[k].carry <= cout[k];
`endif
            end
        end
    end

endmodule

// File: tb/tb_bshift_pipe.sv
// tb_bshift_pipe: directed vectors, reset flush and randomized back-pressure
// streams on 8-bit and 12-bit instances against a closed-form shift model.
module tb_bshift_pipe;

    localparam logic [1:0] LSL = 2'd0;
    localparam logic [1:0] LSR = 2'd1;
    localparam logic [1:0] ROL = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    typedef struct {
        int          w;
        logic [11:0] x;
        logic [3:0]  s;
        logic [1:0]  m;
        logic        ar;
        logic [11:0] ed;
        logic        ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bshift_if #(.DSIZE(8))  if8 ();
    bshift_if #(.DSIZE(12)) if12 ();

    bshift_pipe #(.DSIZE(8))  u8  (.clk(clk), .rst(rst), .io(if8));
    bshift_pipe #(.DSIZE(12)) u12 (.clk(clk), .rst(rst), .io(if12));

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(int w, logic v, logic [11:0] d, logic [3:0] s,
                       logic [1:0] m, logic ar);
        if (w == 8) begin
            if8.in_valid  = v;
            if8.in_data   = d[7:0];
            if8.in_amount = s[2:0];
            if8.in_mode   = m;
            if8.in_arith  = ar;
        end else begin
            if12.in_valid  = v;
            if12.in_data   = d;
            if12.in_amount = s;
            if12.in_mode   = m;
            if12.in_arith  = ar;
        end
    endtask

    task automatic rdy(int w, logic r);
        if (w == 8) if8.out_ready = r;
        else        if12.out_ready = r;
    endtask

    function automatic logic ovalid(int w);
        return (w == 8) ? if8.out_valid : if12.out_valid;
    endfunction

    function automatic logic inrdy(int w);
        return (w == 8) ? if8.in_ready : if12.in_ready;
    endfunction

    function automatic logic [11:0] odata(int w);
        return (w == 8) ? {4'h0, if8.out_data} : if12.out_data;
    endfunction

`ifdef BSHIFT_CARRY_EN
    function automatic logic ocarry(int w);
        return (w == 8) ? if8.out_carry : if12.out_carry;
    endfunction
`endif

    // Closed-form result {carry, data} of a w-bit shift/rotate by s.
    function automatic logic [64:0] model(int w, logic [63:0] xin, int s,
                                          logic [1:0] m, logic ar);
        logic [63:0] mask, x, d;
        logic        c, sg;
        int          r;
        mask = (64'd1 << w) - 64'd1;
        x    = xin & mask;
        sg   = x[w-1];
        r    = s % w;
        d    = '0;
        c    = 1'b0;
        case (m)
            LSL: begin
                d = (s >= w) ? 64'd0 : ((x << s) & mask);
                c = (s >= 1 && s <= w) ? x[w-s] : 1'b0;
            end
            LSR: begin
                if (ar && sg)
                    d = (s >= w) ? mask : ((x >> s) | (mask & ~(mask >> s)));
                else
                    d = (s >= w) ? 64'd0 : (x >> s);
                c = (s == 0) ? 1'b0 : (s <= w) ? x[s-1] : (ar & sg);
            end
            ROL: begin
                d = ((x << r) | (x >> (w - r))) & mask;
                c = (s == 0) ? 1'b0 : x[(w - r) % w];
            end
            default: begin
                d = ((x >> r) | (x << (w - r))) & mask;
                c = (s == 0) ? 1'b0 : x[(r + w - 1) % w];
            end
        endcase
        return {c, d};
    endfunction

    task automatic run_vec(string nm, vec_t v);
        int la;
        la = (v.w == 8) ? 3 : 4;
        @(negedge clk);
        rdy(v.w, 1'b1);
        put(v.w, 1'b1, v.x, v.s, v.m, v.ar);
        for (int i = 1; i <= la; i++) begin
            @(negedge clk);
            if (i == 1) put(v.w, 1'b0, 12'h0, 4'h0, LSL, 1'b0);
            if (i == la - 1) check({nm, "_early"}, 64'(ovalid(v.w)), 64'd0);
        end
        check({nm, "_vld"}, 64'(ovalid(v.w)), 64'd1);
        check({nm, "_data"}, 64'(odata(v.w)), 64'(v.ed));
`ifdef BSHIFT_CARRY_EN
        check({nm, "_carry"}, 64'(ocarry(v.w)), 64'(v.ec));
`endif
    endtask

    task automatic rand_run(int w, int nbeats);
        logic [12:0] q[$];
        logic [12:0] e;
        logic [64:0] me;
        logic [11:0] x, hd;
        logic [3:0]  s;
        logic [1:0]  m;
        logic        ar, v, r, held;
        int          sent, got, cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        hd   = '0;
        while ((sent < nbeats || q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (held) check($sformatf("w%0d_stall_hold", w), 64'(odata(w)), 64'(hd));
            r  = ($urandom_range(0, 1) == 1);
            v  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            x  = 12'($urandom);
            s  = 4'($urandom);
            m  = 2'($urandom);
            ar = 1'($urandom);
            if (w == 8) begin
                x[11:8] = 4'h0;
                s[3]    = 1'b0;
            end
            rdy(w, r);
            put(w, v, x, s, m, ar);
            #1;
            if (v && inrdy(w)) begin
                me = model(w, 64'(x), int'(s), m, ar);
                q.push_back({me[64], me[11:0]});
                sent++;
            end
            held = ovalid(w) && !r;
            hd   = odata(w);
            if (ovalid(w) && r) begin
                got++;
                if (q.size() == 0) begin
                    check($sformatf("w%0d_extra_beat", w), 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("w%0d_beat%0d_data", w, got),
                          64'(odata(w)), 64'(e[11:0]));
`ifdef BSHIFT_CARRY_EN
                    check($sformatf("w%0d_beat%0d_carry", w, got),
                          64'(ocarry(w)), 64'(e[12]));
`endif
                end
            end
        end
        check($sformatf("w%0d_stream_timeout", w), 64'(cyc >= 2000), 64'd0);
        check($sformatf("w%0d_beat_count", w), 64'(got), 64'(nbeats));
        @(negedge clk);
        put(w, 1'b0, 12'h0, 4'h0, LSL, 1'b0);
        rdy(w, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv [14];
        vec_t pr;

        tv[0]  = '{8,  12'h081, 4'd1,  LSL, 1'b0, 12'h002, 1'b1};
        tv[1]  = '{8,  12'h081, 4'd1,  LSR, 1'b0, 12'h040, 1'b1};
        tv[2]  = '{8,  12'h001, 4'd1,  ROR, 1'b0, 12'h080, 1'b1};
        tv[3]  = '{8,  12'h096, 4'd11, ROL, 1'b0, 12'h0B4, 1'b0};
        tv[4]  = '{8,  12'h080, 4'd3,  LSR, 1'b1, 12'h0F0, 1'b0};
        tv[5]  = '{8,  12'h080, 4'd3,  LSR, 1'b0, 12'h010, 1'b0};
        tv[6]  = '{12, 12'hFFF, 4'd13, LSL, 1'b0, 12'h000, 1'b0};
        tv[7]  = '{12, 12'h801, 4'd12, ROL, 1'b0, 12'h801, 1'b1};
        tv[8]  = '{8,  12'h0A5, 4'd0,  LSL, 1'b0, 12'h0A5, 1'b0};
        tv[9]  = '{8,  12'h0A5, 4'd0,  ROR, 1'b1, 12'h0A5, 1'b0};
        tv[10] = '{8,  12'h080, 4'd7,  LSR, 1'b1, 12'h0FF, 1'b0};
        tv[11] = '{12, 12'h800, 4'd15, LSR, 1'b1, 12'hFFF, 1'b1};
        tv[12] = '{12, 12'h800, 4'd15, LSR, 1'b0, 12'h000, 1'b0};
        tv[13] = '{12, 12'h001, 4'd13, ROR, 1'b0, 12'h800, 1'b1};
        pr     = '{12, 12'h00F, 4'd4,  LSL, 1'b0, 12'h0F0, 1'b0};

        rst = 1'b1;
        put(8, 1'b0, 12'h0, 4'h0, LSL, 1'b0);
        put(12, 1'b0, 12'h0, 4'h0, LSL, 1'b0);
        rdy(8, 1'b1);
        rdy(12, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld8",  64'(ovalid(8)),  64'd0);
        check("rst_data8", 64'(odata(8)),   64'd0);
        check("rst_rdy8",  64'(inrdy(8)),   64'd1);
        check("rst_vld12", 64'(ovalid(12)), 64'd0);
        check("rst_data12", 64'(odata(12)), 64'd0);
        check("rst_rdy12", 64'(inrdy(12)),  64'd1);
`ifdef BSHIFT_CARRY_EN
        check("rst_carry8",  64'(ocarry(8)),  64'd0);
        check("rst_carry12", 64'(ocarry(12)), 64'd0);
`endif

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), tv[i]);
        end

        // three beats in flight on the 4-stage instance, then reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            put(12, 1'b1, 12'h0A0 + 12'(i), 4'd1, LSL, 1'b0);
        end
        @(negedge clk);
        put(12, 1'b0, 12'h0, 4'h0, LSL, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flush_vld", 64'(ovalid(12)), 64'd0);
        check("flush_rdy", 64'(inrdy(12)),  64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("flush_quiet%0d", i), 64'(ovalid(12)), 64'd0);
        end
        run_vec("post_rst", pr);

        rand_run(12, 20);
        rand_run(8, 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
